// File: rtl/dice_pkg.sv
// Shared constants, state encodings and helpers for the two-player dice roller.
package dice_pkg;

    localparam logic [2:0] DIE_MIN = 3'd1;
    localparam logic [2:0] DIE_MAX = 3'd6;

    localparam logic [1:0] A_WAIT  = 2'd0;
    localparam logic [1:0] A_PULSE = 2'd1;
    localparam logic [1:0] B_WAIT  = 2'd2;
    localparam logic [1:0] B_PULSE = 2'd3;

    localparam int DEBOUNCE_DEFAULT = 16;

    typedef struct packed {
        logic [3:0] count;
        logic [2:0] die1;
        logic [2:0] die2;
    } roll_t;

    function automatic logic [2:0] next_face(input logic [2:0] face);
        return (face == DIE_MAX) ? DIE_MIN : face + 3'd1;
    endfunction

    function automatic logic [3:0] face_sum(input logic [2:0] a, input logic [2:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/dice_roller_if.sv
// Player keys in, roll result and strobes out.
interface dice_roller_if;

    logic       keya_n;
    logic       keyb_n;
    logic [3:0] count;
    logic       throwa;
    logic       throwb;
    logic [2:0] die1;
    logic [2:0] die2;
    logic       turn;

    modport master (
        output keya_n, keyb_n,
        input  count, throwa, throwb, die1, die2, turn
    );

    modport slave (
        input  keya_n, keyb_n,
        output count, throwa, throwb, die1, die2, turn
    );

endinterface

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low key; pulses press for one cycle on
// each accepted 1->0 transition of the debounced level.
module key_debounce
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clkin,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_r;
    logic       sync2_r;
    logic       level_r;
    logic [7:0] cnt_r;
    logic       press_r;

    // Synchronizer, stability counter and press-event register.
    always_ff @(posedge clkin) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            cnt_r   <= 8'd0;
            press_r <= 1'b0;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r != level_r) begin
                if (cnt_r == LAST_CNT) begin
                    level_r <= sync2_r;
                    cnt_r   <= 8'd0;
                    // Old level high means the key just became pressed.
                    press_r <= level_r;
                end else begin
                    cnt_r <= cnt_r + 8'd1;
                end
            end else begin
                cnt_r <= 8'd0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/dice_roller.sv
// Two-player dice roller: free-running face counters sampled on the in-turn
// player's debounced press, with a one-cycle active-low throw strobe.
module dice_roller
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic          clkin,
    input  logic          reset,
    dice_roller_if.slave  bus
);

    logic       press_a_s;
    logic       press_b_s;
    logic [2:0] fa_r;
    logic [2:0] fb_r;
    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic       capture_s;
    roll_t      roll_r;
    logic       throwa_r;
    logic       throwb_r;
    logic       turn_r;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_a (
        .clkin (clkin),
        .reset (reset),
        .key_n (bus.keya_n),
        .press (press_a_s)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_b (
        .clkin (clkin),
        .reset (reset),
        .key_n (bus.keyb_n),
        .press (press_b_s)
    );

    // Face counters: fb steps only when fa wraps, giving 36 distinct pairs.
    always_ff @(posedge clkin) begin
        if (reset) begin
            fa_r <= DIE_MIN;
            fb_r <= DIE_MIN;
        end else begin
            fa_r <= next_face(fa_r);
            if (fa_r == DIE_MAX) begin
                fb_r <= next_face(fb_r);
            end
        end
    end

    // Turn sequencing; presses outside the owner's WAIT state are dropped.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            A_WAIT: begin
                if (press_a_s) begin
                    state_nxt_s = A_PULSE;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = A_WAIT;
                end
            end
            A_PULSE: state_nxt_s = B_WAIT;
            B_WAIT: begin
                if (press_b_s) begin
                    state_nxt_s = B_PULSE;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = B_WAIT;
                end
            end
            B_PULSE: state_nxt_s = A_WAIT;
            default: state_nxt_s = A_WAIT;
        endcase
    end

    // State, latched roll and registered strobes/turn derived from next state.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_r       <= A_WAIT;
            roll_r.count  <= 4'd0;
            roll_r.die1   <= DIE_MIN;
            roll_r.die2   <= DIE_MIN;
            throwa_r      <= 1'b1;
            throwb_r      <= 1'b1;
            turn_r        <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                roll_r.count <= face_sum(fa_r, fb_r);
                roll_r.die1  <= fa_r;
                roll_r.die2  <= fb_r;
            end
            throwa_r <= (state_nxt_s != A_PULSE);
            throwb_r <= (state_nxt_s != B_PULSE);
            turn_r   <= (state_nxt_s == B_WAIT) || (state_nxt_s == B_PULSE);
        end
    end

    assign bus.count  = roll_r.count;
    assign bus.die1   = roll_r.die1;
    assign bus.die2   = roll_r.die2;
    assign bus.throwa = throwa_r;
    assign bus.throwb = throwb_r;
    assign bus.turn   = turn_r;

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller with a face-counter model and a queue of
// expected strobes checked on every falling clock edge.
module tb_dice_roller;
    import dice_pkg::*;

    logic clkin = 1'b0;
    logic reset;

    dice_roller_if bus ();

    dice_roller #(.DEBOUNCE_CYCLES(4)) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    int         vectors = 0;
    int         miscompares = 0;
    int         exp_q[$];
    logic [2:0] m_fa, m_fb, p_fa, p_fb;
    logic [3:0] exp_count, last_cnt, saved_cnt;
    logic [2:0] exp_d1, exp_d2;
    logic       exp_turn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the face model at the rising edge, check at the falling edge.
    task automatic step();
        int         exp_p;
        logic [1:0] exp_strobes;
        @(posedge clkin);
        p_fa = m_fa;
        p_fb = m_fb;
        if (reset) begin
            m_fa = 3'd1; m_fb = 3'd1;
            exp_count = 4'd0; exp_d1 = 3'd1; exp_d2 = 3'd1; exp_turn = 1'b0;
            exp_q.delete();
        end else if (m_fa == 3'd6) begin
            m_fa = 3'd1;
            m_fb = (m_fb == 3'd6) ? 3'd1 : m_fb + 3'd1;
        end else begin
            m_fa = m_fa + 3'd1;
        end
        @(negedge clkin);
        check("throw_exclusive", 32'(bus.throwa | bus.throwb), 32'd1);
        if (!bus.throwa || !bus.throwb) begin
            exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 2;
            exp_strobes = (exp_p == 0) ? 2'b01 : (exp_p == 1) ? 2'b10 : 2'b11;
            check("strobe_player", 32'({bus.throwa, bus.throwb}), 32'(exp_strobes));
            check("strobe_die1", 32'(bus.die1), 32'(p_fa));
            check("strobe_die2", 32'(bus.die2), 32'(p_fb));
            check("strobe_count", 32'(bus.count), 32'({1'b0, p_fa} + {1'b0, p_fb}));
            check("strobe_sum", 32'(bus.count), 32'({1'b0, bus.die1} + {1'b0, bus.die2}));
            check("strobe_turn", 32'(bus.turn), 32'(exp_turn));
            exp_count = {1'b0, p_fa} + {1'b0, p_fb};
            exp_d1    = p_fa;
            exp_d2    = p_fb;
            exp_turn  = !bus.throwa;
            last_cnt  = bus.count;
        end else begin
            check("hold_count", 32'(bus.count), 32'(exp_count));
            check("hold_die1", 32'(bus.die1), 32'(exp_d1));
            check("hold_die2", 32'(bus.die2), 32'(exp_d2));
            check("turn", 32'(bus.turn), 32'(exp_turn));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input bit key_b);
        if (key_b) bus.keyb_n = 1'b0; else bus.keya_n = 1'b0;
        run(10);
        bus.keya_n = 1'b1;
        bus.keyb_n = 1'b1;
        run(8);
        check("pending_strobes", 32'(exp_q.size()), 32'd0);
    endtask

    // Run until the model's face-pair index reaches target (0..35).
    task automatic wait_idx(input int target);
        int k = 0;
        while (((int'(m_fb) - 1) * 6 + (int'(m_fa) - 1)) != target && k < 40) begin
            step();
            k++;
        end
        check("align_timeout", 32'(k < 40), 32'd1);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        bus.keya_n = 1'b1;
        bus.keyb_n = 1'b1;
        m_fa = 3'd1; m_fb = 3'd1; p_fa = 3'd1; p_fb = 3'd1;
        exp_count = 4'd0; exp_d1 = 3'd1; exp_d2 = 3'd1; exp_turn = 1'b0;
        last_cnt = 4'd0;
        run(3);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_die1", 32'(bus.die1), 32'd1);
        check("rst_die2", 32'(bus.die2), 32'd1);
        check("rst_throwa", 32'(bus.throwa), 32'd1);
        check("rst_throwb", 32'(bus.throwb), 32'd1);
        check("rst_turn", 32'(bus.turn), 32'd0);
        reset = 1'b0;
        run(7);
        check("free_fa", 32'(dut.fa_r), 32'd2);
        check("free_fb", 32'(dut.fb_r), 32'd2);

        // Steady A press, then B press hands the turn back.
        exp_q.push_back(0);
        press(1'b0);
        check("turn_after_a", 32'(bus.turn), 32'd1);
        exp_q.push_back(1);
        press(1'b1);

        // Bouncing A key never holds a level for four cycles.
        saved_cnt = bus.count;
        for (int i = 0; i < 20; i++) begin
            bus.keya_n = ((i / 2) % 2) != 0;
            step();
        end
        bus.keya_n = 1'b1;
        run(8);
        check("bounce_count", 32'(bus.count), 32'(saved_cnt));
        check("bounce_pending", 32'(exp_q.size()), 32'd0);

        // Out-of-turn presses are discarded.
        press(1'b1);
        exp_q.push_back(0);
        press(1'b0);
        press(1'b0);
        exp_q.push_back(1);
        press(1'b1);
        check("turn_after_b", 32'(bus.turn), 32'd0);

        // Simultaneous press, then reset lands on the A strobe cycle.
        exp_q.push_back(0);
        bus.keya_n = 1'b0;
        bus.keyb_n = 1'b0;
        k = 0;
        while (bus.throwa && k < 20) begin
            step();
            k++;
        end
        check("both_strobe_timeout", 32'(k < 20), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("pulse_rst_throwa", 32'(bus.throwa), 32'd1);
        check("pulse_rst_count", 32'(bus.count), 32'd0);
        check("pulse_rst_state", 32'(dut.state_r), 32'(A_WAIT));
        // Keys held across reset release debounce afresh into one A press.
        exp_q.push_back(0);
        run(12);
        bus.keya_n = 1'b1;
        bus.keyb_n = 1'b1;
        run(8);
        check("held_pending", 32'(exp_q.size()), 32'd0);

        // Face extremes: the capture sees the pair six steps after the key drops.
        exp_q.push_back(1);
        press(1'b1);
        wait_idx(29);
        exp_q.push_back(0);
        press(1'b0);
        check("max_count", 32'(last_cnt), 32'd12);
        exp_q.push_back(1);
        press(1'b1);
        wait_idx(30);
        exp_q.push_back(0);
        press(1'b0);
        check("min_count", 32'(last_cnt), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
